// File: rtl/gp_reg_arbiter.sv
// gp_reg_arbiter
// Round-robin arbiter between two write requesters (A = ALU writeback,
// B = load path) for the single write port of a small register file.
// The winning write is held in a one-entry write stage that drives the
// register file write port on the following cycle. Reads that hit the
// staged address are stalled for one cycle, or are served from the stage
// when GP_ARB_FORWARD_EN is defined.
module gp_reg_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    output logic              wr_ack_a,
    input  logic              wr_req_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    output logic              wr_ack_b,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    output logic              reg_write,
    output logic [ADDR_W-1:0] in_address,
    output logic [DATA_W-1:0] in_data,
    output logic              read_en
);

    localparam logic PICK_A = 1'b0;
    localparam logic PICK_B = 1'b1;

    logic              rr_ptr_reg;
    logic              stage_vld_reg;
    logic [ADDR_W-1:0] stage_addr_reg;
    logic [DATA_W-1:0] stage_data_reg;

    logic              grant_a;
    logic              grant_b;
    logic              stage_live;

    logic [1:0][ADDR_W-1:0] rd_addr_vec;
    logic [1:0][DATA_W-1:0] rf_out_vec;
    logic [1:0][DATA_W-1:0] rd_data_vec;
    logic [1:0]             hit;

    // A wins when alone or when favoured; B likewise. Reset silences both.
    assign grant_a = ~reset & wr_req_a & (~wr_req_b | (rr_ptr_reg == PICK_A));
    assign grant_b = ~reset & wr_req_b & (~wr_req_a | (rr_ptr_reg == PICK_B));

    assign wr_ack_a = grant_a;
    assign wr_ack_b = grant_b;

    // Gating with reset discards a staged write caught by reset so it never commits.
    assign stage_live = stage_vld_reg & ~reset;

    assign reg_write  = stage_live;
    assign in_address = stage_addr_reg;
    assign in_data    = stage_data_reg;
    assign read_en    = rd_req;

    assign rd_addr_vec = {rd_addr2, rd_addr1};
    assign rf_out_vec  = {rf_out2, rf_out1};

    // Per read port: hazard against the write stage and operand selection.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            assign hit[gi] = stage_live & (stage_addr_reg == rd_addr_vec[gi]);
`ifdef GP_ARB_FORWARD_EN
            assign rd_data_vec[gi] = hit[gi] ? stage_data_reg : rf_out_vec[gi];
`else
            assign rd_data_vec[gi] = rf_out_vec[gi];
`endif
        end
    endgenerate

    assign rd_data1 = rd_data_vec[0];
    assign rd_data2 = rd_data_vec[1];

`ifdef GP_ARB_FORWARD_EN
    assign rd_ready = ~reset & rd_req;
`else
    assign rd_ready = ~reset & rd_req & ~(|hit);
`endif

    // Round-robin pointer and write stage; the loser of a grant is favoured next.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg     <= PICK_A;
            stage_vld_reg  <= 1'b0;
            stage_addr_reg <= '0;
            stage_data_reg <= '0;
        end else if (grant_a) begin
            rr_ptr_reg     <= PICK_B;
            stage_vld_reg  <= 1'b1;
            stage_addr_reg <= wr_addr_a;
            stage_data_reg <= wr_data_a;
        end else if (grant_b) begin
            rr_ptr_reg     <= PICK_A;
            stage_vld_reg  <= 1'b1;
            stage_addr_reg <= wr_addr_b;
            stage_data_reg <= wr_data_b;
        end else begin
            stage_vld_reg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gp_reg_arbiter.sv
// tb_gp_reg_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level model: a favoured-requester variable, a queue of the
// single in-flight write and the architectural register contents.
// Build with GP_ARB_FORWARD_EN defined to check the forwarding variant.
module tb_gp_reg_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req_a, wr_req_b, rd_req;
    logic [1:0] wr_addr_a, wr_addr_b, rd_addr1, rd_addr2;
    logic [7:0] wr_data_a, wr_data_b;
    logic       wr_ack_a, wr_ack_b, rd_ready, reg_write, read_en;
    logic [7:0] rd_data1, rd_data2, rf_out1, rf_out2, in_data;
    logic [1:0] in_address;

    always #5 clk = ~clk;

    gp_reg_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_ack_a(wr_ack_a),
        .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_ack_b(wr_ack_b),
        .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_ready(rd_ready),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .reg_write(reg_write), .in_address(in_address), .in_data(in_data), .read_en(read_en)
    );

    // Register file the arbiter writes into (environment, not the reference).
    logic [7:0] rf_mem [4] = '{default: 8'h00};
    always @(posedge clk) if (reg_write) rf_mem[in_address] <= in_data;
    assign rf_out1 = rf_mem[rd_addr1];
    assign rf_out2 = rf_mem[rd_addr2];

`ifdef GP_ARB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct packed { logic [1:0] addr; logic [7:0] data; } wr_t;
    wr_t        inflight[$];          // write granted last cycle, commits this cycle
    logic [7:0] arch_reg [4] = '{default: 8'h00};
    bit         favour_b = 1'b0;      // which requester wins a tie
    bit         fresh_reset = 1'b0;
    bit         exp_a, exp_b, exp_rdy;

    // Drive one cycle of inputs, let it settle, check every output against the model.
    task automatic apply(input bit r, input bit ra, input logic [1:0] aa, input logic [7:0] da,
                         input bit rb, input logic [1:0] ab, input logic [7:0] db,
                         input bit rq, input logic [1:0] a1, input logic [1:0] a2);
        bit h1, h2, wr_now;
        logic [7:0] e1, e2;
        reset = r; wr_req_a = ra; wr_addr_a = aa; wr_data_a = da;
        wr_req_b = rb; wr_addr_b = ab; wr_data_b = db;
        rd_req = rq; rd_addr1 = a1; rd_addr2 = a2;
        #2;
        exp_a  = !r && ra && (!rb || !favour_b);
        exp_b  = !r && rb && (!ra || favour_b);
        wr_now = !r && inflight.size() != 0;
        h1 = wr_now && inflight[0].addr == a1;
        h2 = wr_now && inflight[0].addr == a2;
        exp_rdy = !r && rq && (FWD || !(h1 || h2));
        check("wr_ack_a", wr_ack_a, exp_a);
        check("wr_ack_b", wr_ack_b, exp_b);
        check("reg_write", reg_write, wr_now);
        check("read_en", read_en, rq);
        check("rd_ready", rd_ready, exp_rdy);
        if (wr_now) begin
            check("in_address", in_address, inflight[0].addr);
            check("in_data", in_data, inflight[0].data);
        end else if (fresh_reset) begin
            check("rst_in_address", in_address, 0);
            check("rst_in_data", in_data, 0);
        end
        if (exp_rdy) begin
            e1 = (FWD && h1) ? inflight[0].data : arch_reg[a1];
            e2 = (FWD && h2) ? inflight[0].data : arch_reg[a2];
            check("rd_data1", rd_data1, e1);
            check("rd_data2", rd_data2, e2);
        end
    endtask

    // Advance the model across the clock edge, then the clock itself.
    task automatic step();
        if (reset) begin
            inflight.delete();
            favour_b = 1'b0;
            fresh_reset = 1'b1;
        end else begin
            fresh_reset = 1'b0;
            if (inflight.size() != 0) arch_reg[inflight[0].addr] = inflight[0].data;
            inflight.delete();
            if (exp_a) begin
                inflight.push_back('{wr_addr_a, wr_data_a});
                favour_b = 1'b1;
            end else if (exp_b) begin
                inflight.push_back('{wr_addr_b, wr_data_b});
                favour_b = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit r);
        apply(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit hold;
        logic [1:0] ha1, ha2;
        @(posedge clk); #1;

        // Reset state
        idle(1); step(); idle(1); step();
        idle(0); check("rst_reg_write", reg_write, 0); step();

        // A writes R2=0x5A
        apply(0, 1, 2, 8'h5A, 0, 0, 0, 0, 0, 0); check("t1_ack_a", wr_ack_a, 1); step();
        idle(0);
        check("t1_wr", reg_write, 1); check("t1_addr", in_address, 2); check("t1_data", in_data, 8'h5A);
        step();

        // Contention after reset: A first, then B, back-to-back writes
        idle(1); step();
        apply(0, 1, 1, 8'h11, 1, 3, 8'h33, 0, 0, 0); check("t2_ack_a", wr_ack_a, 1); step();
        apply(0, 0, 1, 8'h11, 1, 3, 8'h33, 0, 0, 0);
        check("t2_ack_b", wr_ack_b, 1); check("t2_wr1", reg_write, 1); step();
        idle(0); check("t2_wr2", reg_write, 1); check("t2_addr2", in_address, 3); step();

        // Same target R0: A then B, B's value survives
        apply(0, 1, 0, 8'hAA, 1, 0, 8'hBB, 0, 0, 0); check("t3_ack_a", wr_ack_a, 1); step();
        apply(0, 0, 0, 8'hAA, 1, 0, 8'hBB, 0, 0, 0); check("t3_ack_b", wr_ack_b, 1); step();
        idle(0); step();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); check("t3_r0", rd_data1, 8'hBB); step();

        // Read hazard on R1 while the stage holds R1=0x77
        apply(0, 1, 1, 8'h77, 0, 0, 0, 0, 0, 0); step();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        if (FWD) begin
            check("t4_fwd_rdy", rd_ready, 1); check("t4_fwd_data", rd_data1, 8'h77);
        end else begin
            check("t4_stall", rd_ready, 0);
        end
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        check("t4_rdy", rd_ready, 1); check("t4_data", rd_data1, 8'h77); step();

        // Reset right after a grant discards the staged write
        apply(0, 1, 2, 8'hFF, 0, 0, 0, 0, 0, 0); step();
        idle(1); check("t5_no_commit", reg_write, 0); step();
        apply(0, 1, 1, 8'h01, 1, 3, 8'h03, 1, 2, 2);
        check("t5_r2_kept", rd_data1, 8'h5A); check("t5_ptr_a", wr_ack_a, 1); step();

        // B alone for three cycles, then A is favoured
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, 3, 8'hC0 + 8'(i), 0, 0, 0);
            check("t6_ack_b", wr_ack_b, 1);
            if (i > 0) check("t6_wr", reg_write, 1);
            step();
        end
        apply(0, 1, 0, 8'h44, 1, 1, 8'h55, 0, 0, 0); check("t6_ptr_a", wr_ack_a, 1); step();
        idle(0); step();

        // Randomized traffic; the reader holds its request while stalled
        hold = 0; ha1 = 0; ha2 = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r, rq;
            logic [1:0] a1, a2;
            r  = ($urandom_range(0, 99) < 3);
            rq = hold ? 1'b1 : 1'($urandom_range(0, 1));
            a1 = hold ? ha1 : 2'($urandom);
            a2 = hold ? ha2 : 2'($urandom);
            apply(r, 1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom), rq, a1, a2);
            hold = rq && !exp_rdy && !r;
            ha1 = a1; ha2 = a2;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
